modulation_az_seq: RTL and testbench

Parametrised auto-zero modulation sequencer for the DMM front end. Drives the pre-charge switch, the AZ mux and the ADC start strobe, scanning up to `NCH` hi inputs, each followed by an optional LO (auto-zero) measurement. Sits between the register bank (durations, mux codes, mode) and the ADC controller (`adc_measure_start` / `adc_measure_done`). Tags every completed conversion with its channel and phase for downstream sample assembly.

---
 rtl/modulation_az_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_modulation_az_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulation_az_seq.sv
// Auto-zero modulation sequencer: scans hi channels (each optionally followed by a LO
// auto-zero measurement), drives the pre-charge switch, AZ mux and ADC start strobe.
module modulation_az_seq #(
    parameter int MUX_W = 4,
    parameter int NCH   = 4,
    parameter int CNT_W = 24,
    localparam int CC_W = $clog2(NCH + 1),
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_W-1:0]     precharge_n,
    input  logic [CNT_W-1:0]     timeout_n,
    input  logic                 az_en,
    input  logic [CC_W-1:0]      ch_count,
    input  logic [NCH*MUX_W-1:0] azmux_hi_vals,
    input  logic [MUX_W-1:0]     azmux_lo_val,
    input  logic                 adc_measure_done,
    output logic                 adc_measure_start,
    output logic                 sw_pc_ctl,
    output logic [MUX_W-1:0]     azmux,
    output logic                 sample_valid,
    output logic [CH_W-1:0]      sample_ch,
    output logic                 sample_hi,
    output logic                 adc_timeout,
    output logic                 led0,
    output logic [1:0]           monitor
);

    typedef enum logic [3:0] {
        S_INIT,
        S_PC_WAIT,
        S_HI_SEL,
        S_HI_SETTLE,
        S_HI_START,
        S_HI_WAIT,
        S_PC_BOOT,
        S_PC_BOOT_WAIT,
        S_LO_START,
        S_LO_WAIT,
        S_NEXT
    } state_t;

    localparam logic PC_BOOT   = 1'b0;
    localparam logic PC_SIGNAL = 1'b1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CH_W-1:0]    r_ch;
    logic               r_to_en;
    logic               r_start;
    logic               r_pc;
    logic [MUX_W-1:0]   r_azmux;
    logic               r_valid;
    logic [CH_W-1:0]    r_sample_ch;
    logic               r_sample_hi;
    logic               r_timeout;
    logic               r_led0;
    logic [1:0]         r_monitor;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CH_W-1:0]    w_ch_next;
    logic               w_to_en_next;
    logic               w_start_next;
    logic               w_pc_next;
    logic [MUX_W-1:0]   w_azmux_next;
    logic               w_valid_next;
    logic [CH_W-1:0]    w_sample_ch_next;
    logic               w_sample_hi_next;
    logic               w_timeout_next;
    logic               w_led0_next;
    logic [1:0]         w_monitor_next;

    logic [MUX_W-1:0]   w_hi_codes [NCH];
    logic [CC_W-1:0]    w_eff_cnt;
    logic [CC_W-1:0]    w_ch_inc;
    logic               w_cnt_zero;
    logic               w_to_hit;
    logic               w_conv_end;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_hi_code
            assign w_hi_codes[gi] = azmux_hi_vals[gi*MUX_W +: MUX_W];
        end
    endgenerate

    // Clamp the requested channel count into 1..NCH.
    always_comb begin
        w_eff_cnt = ch_count;
        if (ch_count == '0) begin
            w_eff_cnt = CC_W'(1);
        end else if (ch_count > CC_W'(NCH)) begin
            w_eff_cnt = CC_W'(NCH);
        end
    end

    assign w_ch_inc   = CC_W'(r_ch) + CC_W'(1);
    assign w_cnt_zero = (r_cnt == '0);
    // A timeout only counts when no done arrives in the same clock.
    assign w_to_hit   = r_to_en && w_cnt_zero && !adc_measure_done;
    assign w_conv_end = adc_measure_done || w_to_hit;

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_ch_next        = r_ch;
        w_to_en_next     = r_to_en;
        w_start_next     = 1'b0;
        w_pc_next        = r_pc;
        w_azmux_next     = r_azmux;
        w_valid_next     = 1'b0;
        w_sample_ch_next = r_sample_ch;
        w_sample_hi_next = r_sample_hi;
        w_timeout_next   = r_timeout;
        w_led0_next      = r_led0;
        w_monitor_next   = r_monitor;

        case (r_state)
            S_INIT: begin
                w_pc_next    = PC_BOOT;
                w_cnt_next   = precharge_n;
                w_state_next = S_PC_WAIT;
            end
            S_PC_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_next = S_HI_SEL;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_HI_SEL: begin
                w_azmux_next      = w_hi_codes[r_ch];
                w_monitor_next[0] = 1'b1;
                w_cnt_next        = precharge_n;
                w_state_next      = S_HI_SETTLE;
            end
            S_HI_SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_next = S_HI_START;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_HI_START: begin
                w_pc_next         = PC_SIGNAL;
                w_led0_next       = 1'b1;
                w_monitor_next[1] = 1'b1;
                w_start_next      = 1'b1;
                w_cnt_next        = timeout_n;
                w_to_en_next      = (timeout_n != '0);
                w_state_next      = S_HI_WAIT;
            end
            S_HI_WAIT: begin
                if (w_conv_end) begin
                    w_valid_next     = 1'b1;
                    w_sample_ch_next = r_ch;
                    w_sample_hi_next = 1'b1;
                    w_timeout_next   = r_timeout | w_to_hit;
                    w_state_next     = S_PC_BOOT;
                end else if (r_to_en) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_PC_BOOT: begin
                w_pc_next         = PC_BOOT;
                w_monitor_next[1] = 1'b0;
                w_cnt_next        = precharge_n;
                w_state_next      = S_PC_BOOT_WAIT;
            end
            S_PC_BOOT_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_next = az_en ? S_LO_START : S_NEXT;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_LO_START: begin
                // Switch stays in BOOT here, so the mux may move safely.
                w_azmux_next      = azmux_lo_val;
                w_led0_next       = 1'b0;
                w_monitor_next[0] = 1'b0;
                w_start_next      = 1'b1;
                w_cnt_next        = timeout_n;
                w_to_en_next      = (timeout_n != '0);
                w_state_next      = S_LO_WAIT;
            end
            S_LO_WAIT: begin
                if (w_conv_end) begin
                    w_valid_next     = 1'b1;
                    w_sample_ch_next = r_ch;
                    w_sample_hi_next = 1'b0;
                    w_timeout_next   = r_timeout | w_to_hit;
                    w_state_next     = S_NEXT;
                end else if (r_to_en) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            S_NEXT: begin
                // Also catches a channel index left above a freshly reduced count.
                if (w_ch_inc >= w_eff_cnt) begin
                    w_ch_next = '0;
                end else begin
                    w_ch_next = CH_W'(w_ch_inc);
                end
                w_state_next = S_HI_SEL;
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_ch        <= '0;
            r_to_en     <= 1'b0;
            r_start     <= 1'b0;
            r_pc        <= PC_BOOT;
            r_azmux     <= '0;
            r_valid     <= 1'b0;
            r_sample_ch <= '0;
            r_sample_hi <= 1'b0;
            r_timeout   <= 1'b0;
            r_led0      <= 1'b0;
            r_monitor   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_ch        <= w_ch_next;
            r_to_en     <= w_to_en_next;
            r_start     <= w_start_next;
            r_pc        <= w_pc_next;
            r_azmux     <= w_azmux_next;
            r_valid     <= w_valid_next;
            r_sample_ch <= w_sample_ch_next;
            r_sample_hi <= w_sample_hi_next;
            r_timeout   <= w_timeout_next;
            r_led0      <= w_led0_next;
            r_monitor   <= w_monitor_next;
        end
    end

    assign adc_measure_start = r_start;
    assign sw_pc_ctl         = r_pc;
    assign azmux             = r_azmux;
    assign sample_valid      = r_valid;
    assign sample_ch         = r_sample_ch;
    assign sample_hi         = r_sample_hi;
    assign adc_timeout       = r_timeout;
    assign led0              = r_led0;
    assign monitor           = r_monitor;

endmodule

// File: tb/tb_modulation_az_seq.sv
// Bench for modulation_az_seq: directed scenarios plus randomized configuration, checked
// every cycle against a conversion-level model (channel/phase order, latencies, safety).
module tb_modulation_az_seq;

    localparam int NCH = 4;

    logic        clk;
    logic        reset;
    logic [23:0] precharge_n;
    logic [23:0] timeout_n;
    logic        az_en;
    logic [2:0]  ch_count;
    logic [15:0] azmux_hi_vals;
    logic [3:0]  azmux_lo_val;
    logic        adc_measure_done;
    logic        adc_measure_start;
    logic        sw_pc_ctl;
    logic [3:0]  azmux;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic        sample_hi;
    logic        adc_timeout;
    logic        led0;
    logic [1:0]  monitor;

    modulation_az_seq #(.MUX_W(4), .NCH(NCH), .CNT_W(24)) dut (
        .clk               (clk),
        .reset             (reset),
        .precharge_n       (precharge_n),
        .timeout_n         (timeout_n),
        .az_en             (az_en),
        .ch_count          (ch_count),
        .azmux_hi_vals     (azmux_hi_vals),
        .azmux_lo_val      (azmux_lo_val),
        .adc_measure_done  (adc_measure_done),
        .adc_measure_start (adc_measure_start),
        .sw_pc_ctl         (sw_pc_ctl),
        .azmux             (azmux),
        .sample_valid      (sample_valid),
        .sample_ch         (sample_ch),
        .sample_hi         (sample_hi),
        .adc_timeout       (adc_timeout),
        .led0              (led0),
        .monitor           (monitor)
    );

    int vectors = 0;
    int miscompares = 0;

    int adc_delay;          // clocks from strobe to done pulse; -1 = never
    int edges;              // posedges since reset release
    int cyc = 0;            // negedge count
    int exp_first;          // expected edges to first strobe after reset; <0 = skip
    bit lat_en;
    int lat_exp;
    int last_lat;
    bit log_en;
    int az_log[$];
    int smp_ch_log[$];
    int smp_hi_log[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    function automatic int hi_code(input int ch);
        return int'((azmux_hi_vals >> (ch * 4)) & 16'hF);
    endfunction

    function automatic int next_ch(input int ch, input int cc);
        int eff;
        eff = (cc == 0) ? 1 : ((cc > NCH) ? NCH : cc);
        return (ch + 1 < eff) ? ch + 1 : 0;
    endfunction

    // ADC stand-in: one done pulse adc_delay clocks after the strobe clock.
    initial begin
        int cd;
        cd = -1;
        adc_measure_done = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cd = -1;
                adc_measure_done = 0;
            end else if (adc_measure_start) begin
                cd = adc_delay;
                adc_measure_done = (adc_delay == 0);
            end else if (cd > 0) begin
                cd--;
                adc_measure_done = (cd == 0);
            end else begin
                adc_measure_done = 0;
            end
        end
    end

    initial begin
        edges = 0;
        forever begin
            @(posedge clk);
            edges = reset ? 0 : edges + 1;
        end
    end

    // Model and per-cycle compare
    initial begin
        int exp_ch, exp_lat, strobe_cyc, pending, pc_low, last_hi;
        bit exp_hi, exp_to, sticky, first_pending, have_last_hi;
        logic [3:0] prev_az;
        logic prev_pc, prev_start;
        exp_ch = 0; exp_hi = 1; exp_lat = 0; exp_to = 0; sticky = 0;
        strobe_cyc = 0; pending = 0; pc_low = 0; last_hi = 0;
        first_pending = 1; have_last_hi = 0;
        prev_az = 0; prev_pc = 0; prev_start = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_ch = 0; exp_hi = 1; sticky = 0; pending = 0; pc_low = 0;
                first_pending = 1; have_last_hi = 0;
                prev_az = 0; prev_pc = 0; prev_start = 0;
            end else begin
                if (azmux != prev_az) begin
                    chk("azmux_change_needs_boot", {prev_pc, sw_pc_ctl}, 0);
                    if (log_en) az_log.push_back(int'(azmux));
                end
                if (sw_pc_ctl && !prev_pc)
                    chk("boot_run_before_signal", (pc_low >= int'(precharge_n) + 1), 1);
                pc_low = sw_pc_ctl ? 0 : pc_low + 1;
                if (adc_measure_start) begin
                    chk("strobe_single_clock", prev_start, 0);
                    chk("start_without_pending_sample", pending, 0);
                    pending = 1;
                    chk("start_pc", sw_pc_ctl, exp_hi);
                    chk("start_azmux", azmux, exp_hi ? hi_code(exp_ch) : int'(azmux_lo_val));
                    chk("start_led0", led0, exp_hi);
                    chk("start_monitor", monitor, exp_hi ? 3 : 0);
                    if (first_pending && exp_first > 0)
                        chk("first_strobe_edges", edges, exp_first);
                    first_pending = 0;
                    if (exp_hi) begin
                        if (lat_en && have_last_hi)
                            chk("hi_start_to_hi_start", cyc - last_hi + 1, lat_exp);
                        last_hi = cyc;
                        have_last_hi = 1;
                    end
                    strobe_cyc = cyc;
                    if (adc_delay < 0 || (timeout_n != 0 && adc_delay > int'(timeout_n))) begin
                        exp_lat = int'(timeout_n) + 1;
                        exp_to = 1;
                    end else begin
                        exp_lat = adc_delay + 1;
                        exp_to = 0;
                    end
                end
                if (sample_valid) begin
                    chk("valid_has_one_start", pending, 1);
                    pending = 0;
                    last_lat = cyc - strobe_cyc;
                    chk("valid_latency", last_lat, exp_lat);
                    sticky = sticky | exp_to;
                    chk("adc_timeout", adc_timeout, sticky);
                    chk("sample_ch", sample_ch, exp_ch);
                    chk("sample_hi", sample_hi, exp_hi);
                    $display("sample ch=%0d hi=%0d lat=%0d timeout=%0d", sample_ch, sample_hi,
                             last_lat, adc_timeout);
                    if (log_en) begin
                        smp_ch_log.push_back(int'(sample_ch));
                        smp_hi_log.push_back(int'(sample_hi));
                    end
                    if (exp_hi && az_en) begin
                        exp_hi = 0;
                    end else begin
                        exp_hi = 1;
                        exp_ch = next_ch(exp_ch, int'(ch_count));
                    end
                end
                prev_az = azmux;
                prev_pc = sw_pc_ctl;
                prev_start = adc_measure_start;
            end
        end
    end

    task automatic wait_hi_strobe();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (adc_measure_start === 1'b1 && sw_pc_ctl === 1'b1) return;
        end
        bound_fail("wait_hi_strobe");
    endtask

    task automatic wait_hi_valid();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1 && sample_hi === 1'b1) begin
                #1;
                return;
            end
        end
        bound_fail("wait_hi_valid");
    endtask

    task automatic wait_samples(input int n);
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            #1;
            if (smp_hi_log.size() >= n) return;
        end
        bound_fail("wait_samples");
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, adc_measure_start, 0);
        chk({tag, "_pc"}, sw_pc_ctl, 0);
        chk({tag, "_azmux"}, azmux, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_sample_ch"}, sample_ch, 0);
        chk({tag, "_sample_hi"}, sample_hi, 0);
        chk({tag, "_timeout"}, adc_timeout, 0);
        chk({tag, "_led0"}, led0, 0);
        chk({tag, "_monitor"}, monitor, 0);
    endtask

    task automatic assert_reset(input string tag);
        @(posedge clk);
        #3 reset = 1;
        #1 check_reset_outputs(tag);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 reset = 0;
    endtask

    initial begin
        int exp_az[4];
        reset = 1;
        precharge_n = 9; timeout_n = 0; az_en = 1; ch_count = 1;
        azmux_hi_vals = 16'h0A98; azmux_lo_val = 4'h3;
        adc_delay = 3; lat_en = 0; lat_exp = 0; last_lat = 0;
        log_en = 0; exp_first = -1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");

        // Single channel with auto-zero: hi,lo,hi,lo on ch 0.
        exp_first = 23;
        log_en = 1;
        release_reset();
        wait_samples(4);
        for (int i = 0; i < 4; i++) begin
            chk("seq1_sample_hi", smp_hi_log[i], ((i % 2) == 0) ? 1 : 0);
            chk("seq1_sample_ch", smp_ch_log[i], 0);
        end
        log_en = 0;

        // Hi-to-hi latency with immediate done, counted over both HI_START clocks.
        wait_hi_strobe(); after_edge(); adc_delay = 0;
        wait_hi_strobe(); after_edge(); lat_exp = 28; lat_en = 1;
        wait_hi_strobe();
        wait_hi_strobe(); after_edge(); lat_en = 0;

        // Done lands in the same clock as the timeout.
        wait_hi_strobe(); after_edge(); adc_delay = 5; timeout_n = 5;
        wait_hi_strobe(); wait_hi_valid();
        chk("same_clock_latency", last_lat, 6);
        chk("same_clock_no_timeout", adc_timeout, 0);

        // Done never arrives: timeout after 20 clocks.
        wait_hi_strobe(); after_edge(); adc_delay = -1; timeout_n = 20;
        wait_hi_strobe(); wait_hi_valid();
        chk("timeout_latency", last_lat, 21);
        chk("timeout_set", adc_timeout, 1);
        wait_hi_strobe(); after_edge(); adc_delay = 1; timeout_n = 0;
        wait_hi_valid();
        chk("timeout_sticky", adc_timeout, 1);

        // Three channels, hi only.
        assert_reset("rst_run");
        precharge_n = 4; az_en = 0; ch_count = 3; adc_delay = 2; timeout_n = 0;
        az_log.delete(); smp_ch_log.delete(); smp_hi_log.delete();
        exp_first = 13; log_en = 1;
        release_reset();
        wait_samples(4);
        exp_az = '{8, 9, 10, 8};
        chk("azlog_len_ok", (az_log.size() >= 4), 1);
        if (az_log.size() >= 4)
            for (int i = 0; i < 4; i++) chk("azmux_sequence", az_log[i], exp_az[i]);
        for (int i = 0; i < 4; i++) begin
            chk("seq2_sample_ch", smp_ch_log[i], (i == 3) ? 0 : i);
            chk("seq2_sample_hi", smp_hi_log[i], 1);
        end
        log_en = 0;

        // Reset while waiting in HI_WAIT.
        wait_hi_strobe(); after_edge(); adc_delay = -1; timeout_n = 0;
        wait_hi_strobe();
        repeat (3) @(posedge clk);
        #3 reset = 1;
        #1 check_reset_outputs("rst_hi_wait");
        precharge_n = 9; az_en = 1; ch_count = 2; adc_delay = 0; exp_first = 23;
        release_reset();
        wait_hi_strobe();

        // Reset during the post-hi boot wait.
        wait_hi_valid();
        repeat (2) @(posedge clk);
        #3 reset = 1;
        #1 check_reset_outputs("rst_pc_boot_wait");
        release_reset();
        wait_hi_strobe();

        // Randomized configuration, changed right after each hi start.
        exp_first = -1;
        for (int n = 0; n < 120; n++) begin
            wait_hi_strobe();
            after_edge();
            precharge_n = 24'($urandom_range(0, 50));
            timeout_n = 24'($urandom_range(0, 8));
            az_en = 1'($urandom_range(0, 1));
            ch_count = 3'($urandom_range(0, NCH + 1));
            azmux_hi_vals = 16'($urandom);
            azmux_lo_val = 4'($urandom);
            adc_delay = $urandom_range(0, 7);
            if (adc_delay == 7 && timeout_n != 0) adc_delay = -1;
        end
        wait_hi_strobe();
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
